// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle between the pipeline/AUX/decode side and the register-file write arbiter.
// The master drives requests and read addresses; the slave (arbiter) drives grants and flags.
interface regfile_write_arbiter_if;
    logic        WB_W_En;
    logic [4:0]  WB_W_Addr;
    logic [31:0] WB_W_Data;
    logic        AUX_Valid;
    logic        AUX_Ready;
    logic [4:0]  AUX_Addr;
    logic [31:0] AUX_Data;
    logic [4:0]  REG_R_Addr1;
    logic [4:0]  REG_R_Addr2;
    logic        HAZ1;
    logic        HAZ2;
    logic        STALL_Req;
    logic        REG_W_En;
    logic [4:0]  REG_W_Addr;
    logic [31:0] REG_W_Data;

    modport master (
        output WB_W_En, WB_W_Addr, WB_W_Data,
        output AUX_Valid, AUX_Addr, AUX_Data,
        output REG_R_Addr1, REG_R_Addr2,
        input  AUX_Ready, HAZ1, HAZ2, STALL_Req,
        input  REG_W_En, REG_W_Addr, REG_W_Data
    );

    modport slave (
        input  WB_W_En, WB_W_Addr, WB_W_Data,
        input  AUX_Valid, AUX_Addr, AUX_Data,
        input  REG_R_Addr1, REG_R_Addr2,
        output AUX_Ready, HAZ1, HAZ2, STALL_Req,
        output REG_W_En, REG_W_Addr, REG_W_Data
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback (always wins) and a buffered AUX source,
// with read-hazard flags for pending writes and a stall request when AUX is starved.
module regfile_write_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    regfile_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_WAIT_C = CW'(MAX_WAIT);

    logic [4:0]       ent_addr_r [DEPTH];
    logic [31:0]      ent_data_r [DEPTH];
    logic [DEPTH-1:0] ent_valid_r;
    logic [PW:0]      wr_ptr_r;
    logic [PW:0]      rd_ptr_r;
    logic [CW-1:0]    wait_cnt_r;
    logic             stall_r;
    logic             reg_w_en_r;
    logic [4:0]       reg_w_addr_r;
    logic [31:0]      reg_w_data_r;

    logic             empty_s;
    logic             full_s;
    logic             wb_grant_s;
    logic             pop_s;
    logic             enq_s;
    logic [PW-1:0]    head_s;
    logic [PW-1:0]    tail_s;
    logic [DEPTH-1:0] head_oh_s;
    logic [DEPTH-1:0] tail_oh_s;
    logic [DEPTH-1:0] squash_s;
    logic [DEPTH-1:0] valid_nxt_s;
    logic [PW:0]      wr_ptr_nxt_s;
    logic [PW:0]      rd_ptr_nxt_s;
    logic             full_nxt_s;
    logic [CW-1:0]    wait_cnt_nxt_s;
    logic             stall_nxt_s;
    logic             reg_w_en_nxt_s;
    logic [4:0]       reg_w_addr_nxt_s;
    logic [31:0]      reg_w_data_nxt_s;
    logic             haz1_s;
    logic             haz2_s;

    // Full when the pointers index the same slot on different wraps.
    function automatic logic ptr_full(input logic [PW:0] wp, input logic [PW:0] rp);
        return (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
    endfunction

    // Buffer occupancy, handshake and grant decisions.
    always_comb begin
        empty_s    = (wr_ptr_r == rd_ptr_r);
        full_s     = ptr_full(wr_ptr_r, rd_ptr_r);
        wb_grant_s = bus.WB_W_En && (bus.WB_W_Addr != 5'd0);
        pop_s      = !wb_grant_s && !empty_s;
        enq_s      = bus.AUX_Valid && !full_s && (bus.AUX_Addr != 5'd0);
        head_s     = rd_ptr_r[PW-1:0];
        tail_s     = wr_ptr_r[PW-1:0];
        head_oh_s  = {{(DEPTH-1){1'b0}}, 1'b1} << head_s;
        tail_oh_s  = {{(DEPTH-1){1'b0}}, 1'b1} << tail_s;
    end

    // Valid-bit update: WB squashes older matching entries; the entry enqueued this cycle survives.
    always_comb begin
        squash_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            squash_s[i] = wb_grant_s && (ent_addr_r[i] == bus.WB_W_Addr);
        end
        valid_nxt_s  = (ent_valid_r & ~squash_s & ~({DEPTH{pop_s}} & head_oh_s))
                     | ({DEPTH{enq_s}} & tail_oh_s);
        wr_ptr_nxt_s = wr_ptr_r + {{PW{1'b0}}, enq_s};
        rd_ptr_nxt_s = rd_ptr_r + {{PW{1'b0}}, pop_s};
        full_nxt_s   = ptr_full(wr_ptr_nxt_s, rd_ptr_nxt_s);
    end

    // Starvation counter and stall request next-state.
    always_comb begin
        wait_cnt_nxt_s = {CW{1'b0}};
        stall_nxt_s    = stall_r;
        if (full_s && !pop_s) begin
            wait_cnt_nxt_s = (wait_cnt_r == MAX_WAIT_C) ? wait_cnt_r : wait_cnt_r + CW'(1);
        end else begin
            wait_cnt_nxt_s = {CW{1'b0}};
        end
        if (!full_nxt_s) begin
            stall_nxt_s = 1'b0;
        end else if (wait_cnt_nxt_s == MAX_WAIT_C) begin
            stall_nxt_s = 1'b1;
        end else begin
            stall_nxt_s = stall_r;
        end
    end

    // Write-port selection; a squashed head pops without enabling the write.
    always_comb begin
        reg_w_en_nxt_s   = 1'b0;
        reg_w_addr_nxt_s = reg_w_addr_r;
        reg_w_data_nxt_s = reg_w_data_r;
        if (wb_grant_s) begin
            reg_w_en_nxt_s   = 1'b1;
            reg_w_addr_nxt_s = bus.WB_W_Addr;
            reg_w_data_nxt_s = bus.WB_W_Data;
        end else if (pop_s) begin
            reg_w_en_nxt_s   = ent_valid_r[head_s];
            reg_w_addr_nxt_s = ent_addr_r[head_s];
            reg_w_data_nxt_s = ent_data_r[head_s];
        end else begin
            reg_w_en_nxt_s   = 1'b0;
        end
    end

    // Read hazards against buffered entries and the output stage.
    always_comb begin
        haz1_s = reg_w_en_r && (reg_w_addr_r == bus.REG_R_Addr1);
        haz2_s = reg_w_en_r && (reg_w_addr_r == bus.REG_R_Addr2);
        for (int i = 0; i < DEPTH; i++) begin
            haz1_s = haz1_s | (ent_valid_r[i] && (ent_addr_r[i] == bus.REG_R_Addr1));
            haz2_s = haz2_s | (ent_valid_r[i] && (ent_addr_r[i] == bus.REG_R_Addr2));
        end
        haz1_s = haz1_s && (bus.REG_R_Addr1 != 5'd0);
        haz2_s = haz2_s && (bus.REG_R_Addr2 != 5'd0);
    end

    // Buffer storage and pointers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_r[i] <= 5'd0;
                ent_data_r[i] <= 32'd0;
            end
            ent_valid_r <= {DEPTH{1'b0}};
            wr_ptr_r    <= {(PW+1){1'b0}};
            rd_ptr_r    <= {(PW+1){1'b0}};
        end else begin
            if (enq_s) begin
                ent_addr_r[tail_s] <= bus.AUX_Addr;
                ent_data_r[tail_s] <= bus.AUX_Data;
            end
            ent_valid_r <= valid_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
        end
    end

    // Starvation counter and stall register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_cnt_r <= {CW{1'b0}};
            stall_r    <= 1'b0;
        end else begin
            wait_cnt_r <= wait_cnt_nxt_s;
            stall_r    <= stall_nxt_s;
        end
    end

    // Registered register-file write port.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            reg_w_en_r   <= 1'b0;
            reg_w_addr_r <= 5'd0;
            reg_w_data_r <= 32'd0;
        end else begin
            reg_w_en_r   <= reg_w_en_nxt_s;
            reg_w_addr_r <= reg_w_addr_nxt_s;
            reg_w_data_r <= reg_w_data_nxt_s;
        end
    end

    assign bus.AUX_Ready  = !full_s;
    assign bus.HAZ1       = haz1_s;
    assign bus.HAZ2       = haz2_s;
    assign bus.STALL_Req  = stall_r;
    assign bus.REG_W_En   = reg_w_en_r;
    assign bus.REG_W_Addr = reg_w_addr_r;
    assign bus.REG_W_Data = reg_w_data_r;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (DEPTH=2, MAX_WAIT=4).
module tb_regfile_write_arbiter;
    logic CLK;
    logic RST;
    logic rf_init;
    int   n_cmp;
    int   n_err;
    logic [31:0] rf     [32];
    logic [31:0] exp_rf [32];
    logic [31:0] d      [11];

    regfile_write_arbiter_if bus();

    regfile_write_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register-file model fed by the DUT write port.
    always @(posedge CLK) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (bus.REG_W_En) begin
            rf[bus.REG_W_Addr] <= bus.REG_W_Data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        if (bus.STALL_Req) chk("stall_contract_wb_en", 32'(bus.WB_W_En), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.WB_W_En   = 1'b0;
        bus.WB_W_Addr = 5'd0;
        bus.WB_W_Data = 32'd0;
        bus.AUX_Valid = 1'b0;
        bus.AUX_Addr  = 5'd0;
        bus.AUX_Data  = 32'd0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] v);
        bus.WB_W_En   = 1'b1;
        bus.WB_W_Addr = a;
        bus.WB_W_Data = v;
    endtask

    task automatic aux(input logic [4:0] a, input logic [31:0] v);
        bus.AUX_Valid = 1'b1;
        bus.AUX_Addr  = a;
        bus.AUX_Data  = v;
    endtask

    task automatic chk_w(input string tag, input logic en, input logic [4:0] a, input logic [31:0] v);
        chk({tag, "_en"}, 32'(bus.REG_W_En), 32'(en));
        if (en) begin
            chk({tag, "_addr"}, 32'(bus.REG_W_Addr), 32'(a));
            chk({tag, "_data"}, bus.REG_W_Data, v);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) exp_rf[i] = 32'd0;
        rf_init = 1'b1;
        RST = 1'b1;
        idle();
        bus.REG_R_Addr1 = 5'd0;
        bus.REG_R_Addr2 = 5'd0;
        tick();
        tick();
        chk("rst_w_en", 32'(bus.REG_W_En), 32'd0);
        chk("rst_stall", 32'(bus.STALL_Req), 32'd0);
        chk("rst_aux_ready", 32'(bus.AUX_Ready), 32'd1);
        chk("rst_w_addr", 32'(bus.REG_W_Addr), 32'd0);
        chk("rst_w_data", bus.REG_W_Data, 32'd0);
        RST = 1'b0;
        rf_init = 1'b0;
        tick();

        // WB priority, buffer fill and starvation stall
        wb(5'd5, 32'h11111111);
        aux(5'd7, 32'hA5A5A5A5);
        bus.REG_R_Addr1 = 5'd7;
        #1;
        chk("prio_ready0", 32'(bus.AUX_Ready), 32'd1);
        chk("prio_haz_incoming", 32'(bus.HAZ1), 32'd0);
        tick();
        chk_w("prio_e1", 1'b1, 5'd5, 32'h11111111);
        chk("prio_ready1", 32'(bus.AUX_Ready), 32'd1);
        chk("prio_haz_buf", 32'(bus.HAZ1), 32'd1);
        tick();
        chk_w("prio_e2", 1'b1, 5'd5, 32'h11111111);
        chk("prio_ready_full", 32'(bus.AUX_Ready), 32'd0);
        tick();
        chk("starve_e3", 32'(bus.STALL_Req), 32'd0);
        tick();
        tick();
        chk("starve_e5", 32'(bus.STALL_Req), 32'd0);
        tick();
        chk("starve_e6", 32'(bus.STALL_Req), 32'd1);
        chk_w("prio_e6", 1'b1, 5'd5, 32'h11111111);
        idle();
        tick();
        chk_w("drain_x7a", 1'b1, 5'd7, 32'hA5A5A5A5);
        chk("drain_stall_clr", 32'(bus.STALL_Req), 32'd0);
        chk("drain_ready", 32'(bus.AUX_Ready), 32'd1);
        tick();
        chk_w("drain_x7b", 1'b1, 5'd7, 32'hA5A5A5A5);
        chk("drain_haz_out", 32'(bus.HAZ1), 32'd1);
        tick();
        chk_w("drain_done", 1'b0, 5'd0, 32'd0);
        chk("drain_haz_clr", 32'(bus.HAZ1), 32'd0);
        exp_rf[5] = 32'h11111111;
        exp_rf[7] = 32'hA5A5A5A5;

        // x0 writes from both sources are dropped
        wb(5'd0, 32'h12345678);
        aux(5'd0, 32'hDEADBEEF);
        bus.REG_R_Addr1 = 5'd0;
        #1;
        chk("x0_ready", 32'(bus.AUX_Ready), 32'd1);
        chk("x0_haz", 32'(bus.HAZ1), 32'd0);
        tick();
        chk_w("x0_e1", 1'b0, 5'd0, 32'd0);
        idle();
        tick();
        chk_w("x0_e2", 1'b0, 5'd0, 32'd0);

        // Squash of a buffered entry by a younger WB write
        aux(5'd9, 32'h00000001);
        tick();
        idle();
        bus.REG_R_Addr1 = 5'd9;
        #1;
        chk("sq_haz_buf", 32'(bus.HAZ1), 32'd1);
        chk_w("sq_idle", 1'b0, 5'd0, 32'd0);
        wb(5'd9, 32'h00000002);
        tick();
        chk_w("sq_wb", 1'b1, 5'd9, 32'h00000002);
        chk("sq_haz_out", 32'(bus.HAZ1), 32'd1);
        idle();
        tick();
        chk_w("sq_silent_pop", 1'b0, 5'd0, 32'd0);
        chk("sq_haz_clr", 32'(bus.HAZ1), 32'd0);
        tick();
        chk_w("sq_after", 1'b0, 5'd0, 32'd0);
        exp_rf[9] = 32'h00000002;

        // Same-cycle WB and AUX to one register: AUX entry is not squashed
        wb(5'd12, 32'h00000003);
        aux(5'd12, 32'h00000004);
        tick();
        chk_w("same_wb", 1'b1, 5'd12, 32'h00000003);
        idle();
        tick();
        chk_w("same_aux", 1'b1, 5'd12, 32'h00000004);
        tick();
        chk_w("same_done", 1'b0, 5'd0, 32'd0);
        exp_rf[12] = 32'h00000004;

        // Asynchronous reset with two entries buffered
        wb(5'd5, 32'h11111111);
        aux(5'd20, 32'h00000001);
        tick();
        aux(5'd21, 32'h00000002);
        tick();
        bus.AUX_Valid = 1'b0;
        bus.REG_R_Addr1 = 5'd20;
        bus.REG_R_Addr2 = 5'd21;
        #1;
        chk("mrst_haz1_pre", 32'(bus.HAZ1), 32'd1);
        chk("mrst_haz2_pre", 32'(bus.HAZ2), 32'd1);
        chk("mrst_ready_pre", 32'(bus.AUX_Ready), 32'd0);
        RST = 1'b1;
        idle();
        #1;
        chk("mrst_w_en", 32'(bus.REG_W_En), 32'd0);
        chk("mrst_ready", 32'(bus.AUX_Ready), 32'd1);
        chk("mrst_haz1", 32'(bus.HAZ1), 32'd0);
        chk("mrst_haz2", 32'(bus.HAZ2), 32'd0);
        chk("mrst_stall", 32'(bus.STALL_Req), 32'd0);
        tick();
        RST = 1'b0;
        tick();
        chk_w("mrst_post1", 1'b0, 5'd0, 32'd0);
        tick();
        chk_w("mrst_post2", 1'b0, 5'd0, 32'd0);
        chk("mrst_rf20", rf[20], 32'd0);
        chk("mrst_rf21", rf[21], 32'd0);
        bus.REG_R_Addr1 = 5'd0;
        bus.REG_R_Addr2 = 5'd0;

        // Pointer wrap: back-to-back push/pop of x1..x10
        for (int k = 1; k <= 10; k++) begin
            d[k] = $urandom;
            exp_rf[k] = d[k];
            aux(5'(k), d[k]);
            tick();
            if (k > 1) chk_w($sformatf("wrap_x%0d", k - 1), 1'b1, 5'(k - 1), d[k-1]);
        end
        idle();
        tick();
        chk_w("wrap_x10", 1'b1, 5'd10, d[10]);
        tick();
        chk_w("wrap_done", 1'b0, 5'd0, 32'd0);
        tick();

        for (int i = 0; i < 32; i++) begin
            chk($sformatf("rf_x%0d", i), rf[i], exp_rf[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - the in-order pipeline writeback stage (WB);
  - an auxiliary multi-cycle result source (AUX, e.g. divider or late load return).
- WB always wins the port. AUX results are buffered in a small FIFO and drained in idle WB cycles.
- Raises read-hazard flags to decode for registers with a buffered write still pending.
- Requests a pipeline stall to force AUX draining if AUX is starved too long.

Parameters:
- DEPTH, 2, AUX buffer entries (power of two, >=2).
- MAX_WAIT, 4, consecutive cycles a full buffer may wait before STALL_Req asserts.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- WB_W_En  in  1  writeback write request; never back-pressured.
- WB_W_Addr  in  5  writeback destination register.
- WB_W_Data  in  32  writeback data.
- AUX_Valid  in  1  AUX result valid.
- AUX_Ready  out  1  buffer can accept; equals !full (combinational from state).
- AUX_Addr  in  5  AUX destination register.
- AUX_Data  in  32  AUX data.
- REG_R_Addr1  in  5  decode read address, port 1.
- REG_R_Addr2  in  5  decode read address, port 2.
- HAZ1  out  1  REG_R_Addr1 has a pending write; combinational.
- HAZ2  out  1  REG_R_Addr2 has a pending write; combinational.
- STALL_Req  out  1  registered; pipeline must hold WB_W_En=0 while high.
- REG_W_En  out  1  registered write enable to register file.
- REG_W_Addr  out  5  registered write address.
- REG_W_Data  out  32  registered write data.

Behaviour:
- Reset (async, any cycle, mid-operation included):
  - buffer emptied, all entries invalid, wait counter 0;
  - REG_W_En=0, REG_W_Addr=0, REG_W_Data=0, STALL_Req=0;
  - AUX_Ready=1 once RST deasserts.
- Latency: a request granted in cycle N appears on REG_W_* after edge N (1 cycle). The register file commits it at edge N+1.
- Grant per cycle, priority order:
  1. WB_W_En=1 with WB_W_Addr!=0: WB is granted.
  2. Otherwise, if the buffer is not empty: pop the head and grant it.
  3. Otherwise: REG_W_En=0 next cycle.
- x0 handling:
  - WB or AUX writes to address 0 are never forwarded to REG_W_*.
  - An AUX handshake to x0 still completes (accepted and dropped, no enqueue).
- AUX handshake: a transfer occurs when AUX_Valid && AUX_Ready at a clock edge. The entry enqueues at the tail.
- Simultaneous events in one cycle:
  - enqueue and pop both allowed when not full;
  - when full, only a pop frees a slot. AUX_Ready stays low that cycle; no same-cycle pass-through.
- Empty buffer with an AUX transfer and WB idle: the entry is buffered first. Earliest REG_W_En is 2 edges after the transfer (no bypass).
- Squash rule:
  - a granted WB write to address A invalidates every buffered valid entry with Addr==A (WB is program-younger);
  - invalidated entries still occupy their slot and are popped without asserting REG_W_En;
  - an AUX entry enqueued in the same cycle as a matching WB write is not squashed.
- Hazards:
  - HAZn=1 iff REG_R_Addrn!=0 and it matches a valid buffered entry or the output stage (REG_W_En && REG_W_Addr).
  - The incoming AUX entry is excluded until enqueued.
- Starvation counter:
  - increments each cycle the buffer is full and no pop occurs; clears on any pop or when not full;
  - saturates at MAX_WAIT;
  - STALL_Req is set at the edge the counter reaches MAX_WAIT and cleared at the edge the buffer becomes not full.
- Pointers wrap modulo DEPTH; full/empty use an extra wrap bit.
- If the pipeline violates the stall contract (WB_W_En=1 while STALL_Req=1), WB still wins. The bench flags this as an error.

Test Plan:
- Reset: hold RST mid-stream with 2 entries buffered -> REG_W_En=0, AUX_Ready=1, HAZ1=HAZ2=0, STALL_Req=0 immediately; no stale write after release.
- WB priority: WB writes x5=0x11111111 every cycle while AUX pushes x7=0xA5A5A5A5 -> only x5 writes appear; AUX_Ready drops after 2 pushes; x7 written the cycle after WB_W_En falls.
- x0: WB write x0 and AUX write x0=0xDEADBEEF -> REG_W_En never asserts, AUX handshake completes, buffer stays empty.
- Squash and hazard:
  - buffer x9=0x1; read REG_R_Addr1=9 -> HAZ1=1;
  - WB writes x9=0x2 -> x9 final value 0x2, buffered entry popped silently;
  - HAZ1=0 once both the entry and the output stage are clear.
- Starvation: keep buffer full with WB busy 4 cycles -> STALL_Req=1 on 5th cycle. Bench drops WB_W_En -> head drains, STALL_Req=0 one edge later.
- Wrap-around: 10 alternating AUX pushes/pops to x1..x10 with random data -> register file end contents match the reference model exactly; order preserved.
